mem_req_master: RTL and testbench

Initiator for the single-outstanding memory request interface (req / rnw / addr / wdata, with ready / rdata returned). It accepts one command at a time from an upstream valid/ready port and drives the request until the memory signals ready. It then returns a response (read data or write acknowledge) on a valid/ready response port. It sits between test or control logic and the memory responder, whose latency is variable and pseudo-random.

---
 rtl/mem_req_pkg.sv | 22 ++
 rtl/mem_req_master.sv | 131 +++++++++++++
 tb/tb_mem_req_master.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_pkg.sv
// ============================================================================
// Module      : mem_req_pkg
// Description : Shared state encoding and default widths for the memory
//               request master and its memory bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_req_pkg;

   localparam int MRQ_ADDR_W = 4;
   localparam int MRQ_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } mrq_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_req_master.sv
// ============================================================================
// Module      : mem_req_master
// Description : Single-outstanding memory request initiator with valid/ready
//               command and response ports. Optional REQ-state watchdog
//               compiled in with `define MEM_REQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_master
   import mem_req_pkg::*;
#(
   parameter int ADDR_W         = MRQ_ADDR_W,
   parameter int DATA_W         = MRQ_DATA_W,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_rnw_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              req_o,
   output logic              req_rnw_o,
   output logic [ADDR_W-1:0] req_addr_o,
   output logic [DATA_W-1:0] req_wdata_o,
   input  logic              req_ready_i,
   input  logic [DATA_W-1:0] req_rdata_i,
   output logic              busy_o
);

   mrq_state_t        r_state;
   mrq_state_t        w_state_next;
   logic              r_rnw;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              w_timeout;
   logic              w_accept;
   logic              w_done;

   assign w_accept = (r_state == IDLE) && cmd_valid_i;
   assign w_done   = (r_state == REQ) && req_ready_i;

`ifdef MEM_REQ_TIMEOUT_EN
   localparam int              CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_rsp_err;

   // A ready arriving on the final wait cycle takes priority over the timeout.
   assign w_timeout = (r_state == REQ) && !req_ready_i && (r_wait_cnt == C_CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait_cnt <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         if (r_state != REQ) begin
            r_wait_cnt <= '0;
         end else if (!req_ready_i) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (w_done) begin
            r_rsp_err <= 1'b0;
         end else if (w_timeout) begin
            r_rsp_err <= 1'b1;
         end
      end
   end

   assign rsp_err_o = r_rsp_err;
`else
   logic [31:0] w_unused_timeout;

   assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
   assign w_timeout        = 1'b0;
   assign rsp_err_o        = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (cmd_valid_i) w_state_next = REQ;
         REQ:     if (req_ready_i || w_timeout) w_state_next = RSP;
         RSP:     if (rsp_ready_i) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_rnw       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_rdata <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_rnw   <= cmd_rnw_i;
            r_addr  <= cmd_addr_i;
            r_wdata <= cmd_wdata_i;
         end
         if (w_done) begin
            r_rsp_rdata <= r_rnw ? req_rdata_i : '0;
         end else if (w_timeout) begin
            r_rsp_rdata <= '0;
         end
      end
   end

   // Request fields come only from the capture registers so they hold for the whole request.
   assign req_o       = (r_state == REQ);
   assign req_rnw_o   = r_rnw;
   assign req_addr_o  = r_addr;
   assign req_wdata_o = r_wdata;
   assign cmd_ready_o = (r_state == IDLE);
   assign rsp_valid_o = (r_state == RSP);
   assign rsp_rdata_o = r_rsp_rdata;
   assign busy_o      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_req_master.sv
// ============================================================================
// Module      : tb_mem_req_master
// Description : Scoreboard bench for mem_req_master with a random-latency
//               memory responder and response backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_req_master;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_ready_o;
   logic          cmd_rnw_i = 1'b0;
   logic [AW-1:0] cmd_addr_i = '0;
   logic [DW-1:0] cmd_wdata_i = '0;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [DW-1:0] rsp_rdata_o;
   logic          rsp_err_o;
   logic          req_o;
   logic          req_rnw_o;
   logic [AW-1:0] req_addr_o;
   logic [DW-1:0] req_wdata_o;
   logic          req_ready_i;
   logic [DW-1:0] req_rdata_i;
   logic          busy_o;

   always #5 clk = ~clk;

   mem_req_master #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_rnw_i   (cmd_rnw_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_wdata_i (cmd_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .req_o       (req_o),
      .req_rnw_o   (req_rnw_o),
      .req_addr_o  (req_addr_o),
      .req_wdata_o (req_wdata_o),
      .req_ready_i (req_ready_i),
      .req_rdata_i (req_rdata_i),
      .busy_o      (busy_o)
   );

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] ref_mem[16];

   int n_cmp  = 0;
   int n_fail = 0;

   // Responder / backpressure knobs set by the main sequence.
   bit zero_wait = 1'b0;
   int lat_max   = 3;
   int force_lat = -1;
   int bp_len    = 0;
   int check_hi  = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: its own storage, random latency, protocol checks on req_o.
   initial begin
      logic [DW-1:0] mem[16];
      logic [36:0]   cap;
      int            lat, hi, lo;
      bit            prev_req, prev_done, gap_ok;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      cap = '0; lat = 0; hi = 0; lo = 0;
      prev_req = 1'b0; prev_done = 1'b0; gap_ok = 1'b0;
      req_ready_i = 1'b0;
      req_rdata_i = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_req = 1'b0; prev_done = 1'b0; gap_ok = 1'b0;
            hi = 0; lo = 0;
            req_ready_i = zero_wait;
         end else begin
            if (prev_done) begin
               chk("rsp_valid_after_ready", 64'(rsp_valid_o), 64'(1));
               if (!cap[36]) mem[cap[35:32]] = cap[31:0];
            end
            if (req_o) begin
               if (!prev_req) begin
                  if (gap_ok) chk("req_gap_ge2", 64'(lo >= 2), 64'(1));
                  cap = {req_rnw_o, req_addr_o, req_wdata_o};
                  hi  = 0;
                  lat = (force_lat >= 0) ? force_lat : $urandom_range(0, lat_max);
               end else begin
                  chk("req_fields_stable", 64'({req_rnw_o, req_addr_o, req_wdata_o}), 64'(cap));
               end
               hi++;
               req_rdata_i = req_rnw_o ? mem[req_addr_o] : $urandom;
               if (zero_wait || lat == 0) begin
                  req_ready_i = 1'b1;
               end else begin
                  req_ready_i = 1'b0;
                  lat--;
               end
               prev_done = req_ready_i;
            end else begin
               if (prev_req) begin
                  if (check_hi >= 0) chk("req_high_cycles", 64'(hi), 64'(check_hi));
                  lo     = 0;
                  gap_ok = 1'b1;
               end
               lo++;
               req_ready_i = zero_wait;
               prev_done   = 1'b0;
            end
            prev_req = req_o;
         end
      end
   end

   // Downstream backpressure: hold rsp_ready_i low for bp_len cycles of each response.
   initial begin
      int hold;
      hold = 0;
      rsp_ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rsp_valid_o) begin
            if (hold >= bp_len) begin
               rsp_ready_i = 1'b1;
            end else begin
               rsp_ready_i = 1'b0;
               hold++;
            end
         end else begin
            rsp_ready_i = 1'b0;
            hold = 0;
         end
      end
   end

   // Monitor: pops the scoreboard on every accepted response.
   initial begin
      bit          held;
      logic [32:0] hold_v;
      exp_t        e;
      held = 1'b0;
      hold_v = '0;
      forever begin
         @(negedge clk);
         if (reset || !rsp_valid_o) begin
            held = 1'b0;
         end else begin
            if (held) chk("rsp_stable", 64'({rsp_err_o, rsp_rdata_o}), 64'(hold_v));
            chk("cmd_ready_low_in_rsp", 64'(cmd_ready_o), 64'(0));
            if (rsp_ready_i) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL rsp_unexpected: got rdata %0h err %0b, required no response", rsp_rdata_o, rsp_err_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                  chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
               end
               held = 1'b0;
            end else begin
               held   = 1'b1;
               hold_v = {rsp_err_o, rsp_rdata_o};
            end
         end
      end
   end

   task automatic do_cmd(input bit rnw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit push, input bit to_err);
      exp_t e;
      int   budget;
      budget = 0;
      @(negedge clk);
      while (!cmd_ready_o && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      if (!cmd_ready_o) begin
         n_cmp++;
         n_fail++;
         $display("FAIL cmd_accept_wait: got cmd_ready_o 0 after %0d cycles, required 1", budget);
      end
      cmd_valid_i = 1'b1;
      cmd_rnw_i   = rnw;
      cmd_addr_i  = a;
      cmd_wdata_i = d;
      if (push) begin
         e.err = to_err;
         if (to_err) begin
            e.rdata = '0;
         end else if (rnw) begin
            e.rdata = ref_mem[a];
         end else begin
            ref_mem[a] = d;
            e.rdata = '0;
         end
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b0;
      cmd_rnw_i   = 1'($urandom_range(0, 1));
      cmd_addr_i  = 4'($urandom_range(0, 15));
      cmd_wdata_i = $urandom;
      chk("req_one_cycle_after_accept", 64'(req_o), 64'(1));
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      @(negedge clk);
      while ((busy_o || exp_q.size() != 0) && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      if (busy_o || exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL idle_wait: got busy_o %0b pending %0d, required idle with 0 pending", busy_o, exp_q.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got simulation still running, required completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_cmd_ready", 64'(cmd_ready_o), 64'(1));
      chk("reset_req", 64'(req_o), 64'(0));
      chk("reset_rsp_valid", 64'(rsp_valid_o), 64'(0));
      chk("reset_busy", 64'(busy_o), 64'(0));
      chk("reset_rsp_rdata", 64'(rsp_rdata_o), 64'(0));
      chk("reset_rsp_err", 64'(rsp_err_o), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Directed write then read back.
      lat_max = 3;
      do_cmd(1'b0, 4'd3, 32'hDEADBEEF, 1'b1, 1'b0);
      do_cmd(1'b1, 4'd3, 32'h0, 1'b1, 1'b0);
      wait_idle();

      // Zero-wait responder.
      zero_wait = 1'b1;
      check_hi  = 1;
      for (int i = 0; i < 6; i++)
         do_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 1'b1, 1'b0);
      wait_idle();
      zero_wait = 1'b0;
      check_hi  = -1;

      // Variable latency with response backpressure over every address.
      lat_max = 15;
      bp_len  = 5;
      for (int i = 0; i < 16; i++) begin
         do_cmd(1'b0, 4'(i), $urandom, 1'b1, 1'b0);
         do_cmd(1'b1, 4'(i), $urandom, 1'b1, 1'b0);
      end
      wait_idle();
      bp_len = 1;

      // Reset on the second REQ cycle discards the command.
      force_lat = 20;
      do_cmd(1'b1, 4'd5, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_req_low", 64'(req_o), 64'(0));
      chk("abort_cmd_ready", 64'(cmd_ready_o), 64'(1));
      chk("abort_rsp_valid", 64'(rsp_valid_o), 64'(0));
      reset = 1'b0;
      force_lat = -1;
      do_cmd(1'b0, 4'd9, 32'hA5A5_1234, 1'b1, 1'b0);
      do_cmd(1'b1, 4'd9, 32'h0, 1'b1, 1'b0);
      wait_idle();

`ifdef MEM_REQ_TIMEOUT_EN
      // Watchdog expiry, then ready landing exactly on the expiry cycle.
      check_hi  = TO;
      force_lat = 1000;
      do_cmd(1'b1, 4'd3, 32'h0, 1'b1, 1'b1);
      wait_idle();
      force_lat = TO - 1;
      do_cmd(1'b1, 4'd3, 32'h0, 1'b1, 1'b0);
      wait_idle();
      force_lat = -1;
      check_hi  = -1;
`endif

      wait_idle();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
